redor_pipe: RTL and testbench

//  Pipelined, parametrised range-reduction unit: reduces a WID-bit operand over a bit range selected by

---
 rtl/redor_pkg.sv | 16 +
 rtl/redor_mask_gen.sv | 26 ++
 rtl/redor_pipe.sv | 139 +++++++++++++
 tb/tb_redor_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redor_pkg.sv
// redor_pkg: shared definitions for the range-reduction pipeline.
//   - RDM_* mode encodings used on i_mode and carried down the pipeline
//   - chunk_count(): number of CHUNK-wide partial reductions that cover WID bits
package redor_pkg;

  localparam logic [1:0] RDM_ORLO  = 2'b00;  // OR  of b[a:0]   (sticky)
  localparam logic [1:0] RDM_ANDLO = 2'b01;  // AND of b[a:0]   (all-ones)
  localparam logic [1:0] RDM_ORHI  = 2'b10;  // OR  of b[WID-1:a]
  localparam logic [1:0] RDM_XORLO = 2'b11;  // XOR of b[a:0]   (parity)

  // ceil(wid / chunk); the last chunk may be only partly populated.
  function automatic int chunk_count(input int wid, input int chunk);
    return (wid + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/redor_mask_gen.sv
// redor_mask_gen: combinational thermometer-mask generator.
//   a    in   AW   range index (may exceed WID-1)
//   hi   in   1    0: low range b[a:0], 1: high range b[WID-1:a]
//   mask out  WID  bit i set when bit i is inside the selected range
//   oob  out  1    a >= WID
// Low ranges clamp an out-of-range index to WID-1 (all ones, never empty);
// a high range with an out-of-range index is empty (all zeros).
module redor_mask_gen #(
  parameter int WID = 80,
  parameter int AW  = 7
) (
  input  logic [AW-1:0]  a,
  input  logic           hi,
  output logic [WID-1:0] mask,
  output logic           oob
);

  assign oob = (32'(a) >= WID);

  for (genvar i = 0; i < WID; i++) begin : g_bit
    localparam logic [AW-1:0] IDX = AW'(i);
    // oob forces the low mask to all ones (the clamp to WID-1) and the high mask to zero.
    assign mask[i] = hi ? (~oob & (IDX >= a)) : (oob | (IDX <= a));
  end

endmodule

// File: rtl/redor_pipe.sv
// redor_pipe: three-stage pipelined range reduction with valid/ready and tag.
//   clk, rst      clock; asynchronous active-high reset
//   ce            clock enable; when 0 every stage holds
//   i_valid/i_ready, i_mode, i_a, i_b, i_tag   operation input
//   o_valid/o_ready, o, o_oob, o_tag           result output
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. The pipeline advances as a whole (adv = ce & (~o_valid | o_ready));
// i_ready equals adv, so it depends only on ce, o_ready and the output register.
// Stage 1 registers the masked operand, stage 2 the per-chunk partial
// reductions, stage 3 the final result (o, o_oob, o_tag).
module redor_pipe
  import redor_pkg::*;
#(
  parameter int WID   = 80,
  parameter int AW    = 7,
  parameter int CHUNK = 16,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [1:0]      i_mode,
  input  logic [AW-1:0]   i_a,
  input  logic [WID-1:0]  i_b,
  input  logic [TAGW-1:0] i_tag,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o,
  output logic            o_oob,
  output logic [TAGW-1:0] o_tag
);

  localparam int NCH  = chunk_count(WID, CHUNK);
  localparam int PADW = NCH * CHUNK;

  logic adv;
  assign adv     = ce & (~o_valid | o_ready);
  assign i_ready = adv;

  // ---------------- stage 1: clamp and mask ----------------
  logic [WID-1:0] mask;
  logic           oob_d;
  logic [WID-1:0] mb_d;

  redor_mask_gen #(.WID(WID), .AW(AW)) u_mask (
    .a    (i_a),
    .hi   (i_mode == RDM_ORHI),
    .mask (mask),
    .oob  (oob_d)
  );

  // AND mode forces out-of-range bits to 1 so they do not affect the AND.
  assign mb_d = (i_mode == RDM_ANDLO) ? (i_b | ~mask) : (i_b & mask);

  logic            s1_v;
  logic [WID-1:0]  s1_mb;
  logic [1:0]      s1_mode;
  logic            s1_oob;
  logic [TAGW-1:0] s1_tag;

  // ---------------- stage 2: per-chunk reduction ----------------
  logic [PADW-1:0] s1_pad;
  logic [NCH-1:0]  cr_d;

  // Padding bits are neutral for the active operator: 1 for AND, 0 otherwise.
  if (PADW > WID) begin : g_pad
    assign s1_pad = {{(PADW - WID){s1_mode == RDM_ANDLO}}, s1_mb};
  end else begin : g_nopad
    assign s1_pad = s1_mb;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    logic [CHUNK-1:0] seg;
    logic             red;
    assign seg = s1_pad[c*CHUNK +: CHUNK];
    always_comb begin
      red = 1'b0;
      case (s1_mode)
        RDM_ANDLO: red = &seg;
        RDM_XORLO: red = ^seg;
        default:   red = |seg;
      endcase
    end
    assign cr_d[c] = red;
  end

  logic            s2_v;
  logic [NCH-1:0]  s2_cr;
  logic [1:0]      s2_mode;
  logic            s2_oob;
  logic [TAGW-1:0] s2_tag;

  // ---------------- stage 3: combine chunks ----------------
  logic fin_d;
  always_comb begin
    fin_d = 1'b0;
    case (s2_mode)
      RDM_ANDLO: fin_d = &s2_cr;
      RDM_XORLO: fin_d = ^s2_cr;
      default:   fin_d = |s2_cr;
    endcase
  end

  // Valid bits and outputs are reset; in-flight ops are dropped by clearing valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      o_valid <= 1'b0;
      o       <= 1'b0;
      o_oob   <= 1'b0;
      o_tag   <= '0;
    end else if (adv) begin
      s1_v    <= i_valid;
      s2_v    <= s1_v;
      o_valid <= s2_v;
      o       <= fin_d;
      o_oob   <= s2_oob;
      o_tag   <= s2_tag;
    end
  end

  // Internal data registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_mb   <= mb_d;
      s1_mode <= i_mode;
      s1_oob  <= oob_d;
      s1_tag  <= i_tag;
      s2_cr   <= cr_d;
      s2_mode <= s1_mode;
      s2_oob  <= s1_oob;
      s2_tag  <= s1_tag;
    end
  end

endmodule

// File: tb/tb_redor_pipe.sv
// Bench for redor_pipe: reference model computes each result directly from
// the bit range; a transaction queue with per-op advance counts predicts
// o_valid, ordering and stall behaviour.
module tb_redor_pipe;
  import redor_pkg::*;

  localparam int WID   = 80;
  localparam int AW    = 7;
  localparam int CHUNK = 16;
  localparam int TAGW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic            i_valid;
  logic            i_ready;
  logic [1:0]      i_mode;
  logic [AW-1:0]   i_a;
  logic [WID-1:0]  i_b;
  logic [TAGW-1:0] i_tag;
  logic            o_valid;
  logic            o_ready;
  logic            o;
  logic            o_oob;
  logic [TAGW-1:0] o_tag;

  redor_pipe #(.WID(WID), .AW(AW), .CHUNK(CHUNK), .TAGW(TAGW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_mode  (i_mode),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o       (o),
    .o_oob   (o_oob),
    .o_tag   (o_tag)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [TAGW+1:0] exp_q[$];   // {tag, oob, o} in acceptance order
  int              age_q[$];   // advance edges seen by each queued op
  logic [TAGW-1:0] got_tags[$];
  logic            last_xfer, last_ov, last_o, last_oob, last_irdy;
  int              next_tag = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reduction straight from the range definition.
  function automatic logic ref_red(input logic [1:0] m, input int a, input logic [WID-1:0] b);
    logic r;
    int   top_i;
    top_i = (a >= WID) ? WID - 1 : a;
    r = 1'b0;
    case (m)
      RDM_ORLO:  for (int i = 0; i <= top_i; i++) r = r | b[i];
      RDM_XORLO: for (int i = 0; i <= top_i; i++) r = r ^ b[i];
      RDM_ANDLO: begin
        r = 1'b1;
        for (int i = 0; i <= top_i; i++) r = r & b[i];
      end
      default: if (a < WID) for (int i = a; i < WID; i++) r = r | b[i];
    endcase
    return r;
  endfunction

  // Called at the falling edge: compare outputs, then book-keep the coming rising edge.
  task automatic sample();
    logic            exp_ov, adv;
    logic [TAGW+1:0] h;
    exp_ov = (age_q.size() > 0) && (age_q[0] >= 3);
    adv    = ce & (~exp_ov | o_ready);
    check_eq("i_ready", 32'(i_ready), 32'(adv));
    check_eq("o_valid", 32'(o_valid), 32'(exp_ov));
    if (exp_ov) begin
      h = exp_q[0];
      check_eq("o",     32'(o),     32'(h[0]));
      check_eq("o_oob", 32'(o_oob), 32'(h[1]));
      check_eq("o_tag", 32'(o_tag), 32'(h[TAGW+1:2]));
    end
    last_ov   = o_valid;
    last_o    = o;
    last_oob  = o_oob;
    last_irdy = i_ready;
    last_xfer = i_valid & adv;
    if (adv) begin
      if (exp_ov) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        got_tags.push_back(o_tag);
      end
      if (i_valid) begin
        exp_q.push_back({i_tag, (32'(i_a) >= WID), ref_red(i_mode, int'(i_a), i_b)});
        age_q.push_back(0);
      end
      foreach (age_q[k]) age_q[k]++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic v, input logic [1:0] m, input int a,
                        input logic [WID-1:0] b, input logic [TAGW-1:0] t);
    i_valid = v;
    i_mode  = m;
    i_a     = AW'(a);
    i_b     = b;
    i_tag   = t;
  endtask

  function automatic logic [WID-1:0] rand_b();
    logic [95:0] w;
    logic [WID-1:0] b;
    w = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: b = '1;
      1: begin
        b = '1;
        b[$urandom_range(0, WID-1)] = 1'b0;
      end
      default: b = w[WID-1:0];
    endcase
    return b;
  endfunction

  task automatic directed(input string name, input logic [1:0] m, input int a,
                          input logic [WID-1:0] b, input logic eo, input logic eoob);
    int n;
    ce = 1'b1;
    o_ready = 1'b1;
    set_op(1'b1, m, a, b, TAGW'(next_tag));
    next_tag++;
    cycle();
    check_eq({name, "_xfer"}, 32'(last_xfer), 32'd1);
    i_valid = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ov && n < 10);
    check_eq({name, "_lat"}, 32'(n), 32'd3);
    check_eq({name, "_o"},   32'(last_o),   32'(eo));
    check_eq({name, "_oob"}, 32'(last_oob), 32'(eoob));
  endtask

  task automatic run_burst(input bit use_ce);
    int idx = 0;
    int stall_left = 0;
    int guard = 0;
    bit seen = 0;
    got_tags.delete();
    ce = 1'b1;
    o_ready = 1'b1;
    while ((idx < 6 || exp_q.size() > 0) && guard < 60) begin
      if (idx < 6)
        set_op(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 127), rand_b(), TAGW'(idx + 1));
      else
        i_valid = 1'b0;
      if (stall_left > 0) begin
        if (use_ce) ce = 1'b0;
        else o_ready = 1'b0;
        stall_left--;
      end else begin
        ce = 1'b1;
        o_ready = 1'b1;
      end
      cycle();
      if (last_xfer) idx++;
      if (last_ov && !seen) begin
        seen = 1;
        stall_left = 4;
      end
      guard++;
    end
    i_valid = 1'b0;
    ce = 1'b1;
    o_ready = 1'b1;
    check_eq(use_ce ? "ce_burst_done" : "bp_burst_done", 32'(guard < 60), 32'd1);
    check_eq(use_ce ? "ce_burst_cnt" : "bp_burst_cnt", 32'(got_tags.size()), 32'd6);
    for (int k = 0; k < got_tags.size() && k < 6; k++)
      check_eq(use_ce ? "ce_burst_tag" : "bp_burst_tag", 32'(got_tags[k]), 32'(k + 1));
  endtask

  task automatic reset_mid_flight();
    got_tags.delete();
    ce = 1'b1;
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(1'b1, RDM_ORLO, k, rand_b(), TAGW'(10 + k));
      cycle();
    end
    i_valid = 1'b0;
    check_eq("rst_pre_ov", 32'(o_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_ov",  32'(o_valid), 32'd0);
    check_eq("rst_o",   32'(o),       32'd0);
    check_eq("rst_oob", 32'(o_oob),   32'd0);
    check_eq("rst_tag", 32'(o_tag),   32'd0);
    exp_q.delete();
    age_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    cycle();
    check_eq("rst_iready", 32'(last_irdy), 32'd1);
    repeat (6) cycle();
    check_eq("rst_no_results", 32'(got_tags.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WID-1:0] b;
    rst = 1'b1;
    ce = 1'b1;
    o_ready = 1'b1;
    set_op(1'b0, 2'b00, 0, '0, '0);
    repeat (2) @(negedge clk);
    check_eq("reset_o_valid", 32'(o_valid), 32'd0);
    check_eq("reset_o",       32'(o),       32'd0);
    check_eq("reset_o_oob",   32'(o_oob),   32'd0);
    check_eq("reset_o_tag",   32'(o_tag),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // sticky
    b = '0; b[40] = 1'b1;
    directed("orlo_39",  RDM_ORLO, 39,  b, 1'b0, 1'b0);
    directed("orlo_40",  RDM_ORLO, 40,  b, 1'b1, 1'b0);
    directed("orlo_79",  RDM_ORLO, 79,  b, 1'b1, 1'b0);
    directed("orlo_100", RDM_ORLO, 100, b, 1'b1, 1'b1);
    // all-ones
    b = '0; b[9:0] = '1;
    directed("andlo_9",  RDM_ANDLO, 9,  b, 1'b1, 1'b0);
    directed("andlo_10", RDM_ANDLO, 10, b, 1'b0, 1'b0);
    b = '1;
    directed("andlo_127", RDM_ANDLO, 127, b, 1'b1, 1'b1);
    // high range
    b = '0; b[5] = 1'b1;
    directed("orhi_5", RDM_ORHI, 5, b, 1'b1, 1'b0);
    directed("orhi_6", RDM_ORHI, 6, b, 1'b0, 1'b0);
    b = '0; b[79] = 1'b1;
    directed("orhi_79", RDM_ORHI, 79, b, 1'b1, 1'b0);
    directed("orhi_80", RDM_ORHI, 80, b, 1'b0, 1'b1);
    // parity
    b = '0; b[3:0] = 4'b1011;
    directed("xorlo_3", RDM_XORLO, 3, b, 1'b1, 1'b0);
    directed("xorlo_1", RDM_XORLO, 1, b, 1'b0, 1'b0);
    b = '0; b[64] = 1'b1; b[63] = 1'b1;
    directed("xorlo_64", RDM_XORLO, 64, b, 1'b0, 1'b0);

    run_burst(1'b0);
    run_burst(1'b1);
    reset_mid_flight();

    // randomized traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      set_op(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
             $urandom_range(0, 127), rand_b(), TAGW'($urandom_range(0, 63)));
      ce      = ($urandom_range(0, 9) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_valid = 1'b0;
    ce = 1'b1;
    o_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
    check_eq("random_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
